// File: rtl/ws2812_pkg.sv
// Shared types, default timing and pixel conversion for the WS2812 frame-buffer reader.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH0  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_LATCH   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DEF_NUM_LEDS = 256;
  localparam int DEF_T0H      = 11;
  localparam int DEF_T1H      = 22;
  localparam int DEF_T_BIT    = 34;
  localparam int DEF_T_LATCH  = 2160;

  // Channel widening replicates the top bits so full-scale stays full-scale.
  function automatic logic [23:0] rgb565_to_grb888(input logic [15:0] i_word);
    return {i_word[10:5], i_word[10:9],
            i_word[15:11], i_word[15:13],
            i_word[4:0], i_word[4:2]};
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Generates one WS2812 bit period: high for T0H/T1H cycles, low for the rest of T_BIT.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H,
  parameter int T_BIT = DEF_T_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_start,
  input  logic bit_val,
  output logic bit_last,
  output logic ws_dout
);

  localparam int CW = $clog2(T_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] C_T0H  = CW'(T0H);
  localparam logic [CW-1:0] C_T1H  = CW'(T1H);

  logic [CW-1:0] r_cnt;
  logic          r_val;
  logic          r_active;
  logic          r_dout;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_th;

  // High-time threshold for the bit in flight and the next count value.
  always_comb begin
    w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    if (r_val) begin
      w_th = C_T1H;
    end else begin
      w_th = C_T0H;
    end
  end

  // A new bit_start restarts the period even in the last cycle of the previous one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_val    <= 1'b0;
      r_active <= 1'b0;
      r_dout   <= 1'b0;
    end else if (bit_start) begin
      r_cnt    <= '0;
      r_val    <= bit_val;
      r_active <= 1'b1;
      r_dout   <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == C_LAST) begin
        r_cnt    <= '0;
        r_active <= 1'b0;
        r_dout   <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_next;
        r_dout <= (w_cnt_next < w_th);
      end
    end else begin
      r_dout <= 1'b0;
    end
  end

  assign bit_last = r_active && (r_cnt == C_LAST);
  assign ws_dout  = r_dout;

endmodule

// File: rtl/ws2812_frame_reader.sv
// Scans the frame buffer, expands RGB565 to GRB888 and streams a full WS2812 frame plus latch gap.
module ws2812_frame_reader
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T_LATCH  = DEF_T_LATCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] mem_addr,
  output logic        mem_ce,
  input  logic [15:0] mem_dout,
  output logic        ws_dout
);

  localparam int LW = $clog2(T_LATCH + 1);
  localparam logic [11:0]   C_LAST_LED   = 12'(NUM_LEDS - 1);
  localparam logic [LW-1:0] C_LATCH_LAST = LW'(T_LATCH - 1);

  state_t        r_state;
  logic [23:0]   r_shift;
  logic [23:0]   r_pix_next;
  logic [4:0]    r_bit_idx;
  logic [11:0]   r_led;
  logic [11:0]   r_mem_addr;
  logic          r_mem_ce;
  logic          r_cap;
  logic          r_busy;
  logic          r_done;
  logic [LW-1:0] r_latch_cnt;

  logic [23:0]   w_px;
  logic          w_bit_start;
  logic          w_bit_val;
  logic          w_bit_last;
  logic          w_last_bit;
  logic          w_last_led;
  logic          w_more_prefetch;

  // Decide when the encoder starts the next bit and which value it carries.
  always_comb begin
    w_px            = rgb565_to_grb888(mem_dout);
    w_last_bit      = (r_bit_idx == 5'd0);
    w_last_led      = (r_led == C_LAST_LED);
    w_more_prefetch = ((r_led + 12'd1) != C_LAST_LED);
    w_bit_start     = 1'b0;
    w_bit_val       = 1'b0;
    case (r_state)
      ST_CAPTURE: begin
        w_bit_start = 1'b1;
        w_bit_val   = w_px[23];
      end
      ST_SEND: begin
        if (w_bit_last && !w_last_bit) begin
          w_bit_start = 1'b1;
          w_bit_val   = r_shift[22];
        end else if (w_bit_last && !w_last_led) begin
          w_bit_start = 1'b1;
          w_bit_val   = r_pix_next[23];
        end else begin
          w_bit_start = 1'b0;
          w_bit_val   = 1'b0;
        end
      end
      default: begin
        w_bit_start = 1'b0;
        w_bit_val   = 1'b0;
      end
    endcase
  end

  // Frame sequencing: initial fetch, per-LED prefetch at bit 23, shifting, latch gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= 24'd0;
      r_pix_next  <= 24'd0;
      r_bit_idx   <= 5'd0;
      r_led       <= 12'd0;
      r_mem_addr  <= 12'd0;
      r_mem_ce    <= 1'b0;
      r_cap       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_latch_cnt <= '0;
    end else begin
      r_cap    <= r_mem_ce;
      r_mem_ce <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_FETCH0;
            r_busy     <= 1'b1;
            r_mem_ce   <= 1'b1;
            r_mem_addr <= 12'd0;
            r_led      <= 12'd0;
          end
        end
        ST_FETCH0: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_shift   <= w_px;
          r_bit_idx <= 5'd23;
          r_state   <= ST_SEND;
          if (!w_last_led) begin
            r_mem_ce   <= 1'b1;
            r_mem_addr <= 12'd1;
          end
        end
        ST_SEND: begin
          if (r_cap) begin
            r_pix_next <= w_px;
          end
          if (w_bit_last) begin
            if (!w_last_bit) begin
              r_shift   <= {r_shift[22:0], 1'b0};
              r_bit_idx <= r_bit_idx - 5'd1;
            end else if (!w_last_led) begin
              r_shift   <= r_pix_next;
              r_bit_idx <= 5'd23;
              r_led     <= r_led + 12'd1;
              if (w_more_prefetch) begin
                r_mem_ce   <= 1'b1;
                r_mem_addr <= r_led + 12'd2;
              end
            end else begin
              r_state     <= ST_LATCH;
              r_latch_cnt <= '0;
            end
          end
        end
        ST_LATCH: begin
          if (r_latch_cnt == C_LATCH_LAST) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_latch_cnt <= r_latch_cnt + {{(LW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  ws2812_bit_encoder #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT)
  ) u_enc (
    .clk       (clk),
    .reset     (reset),
    .bit_start (w_bit_start),
    .bit_val   (w_bit_val),
    .bit_last  (w_bit_last),
    .ws_dout   (ws_dout)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_addr = r_mem_addr;
  assign mem_ce   = r_mem_ce;

endmodule

// File: tb/tb_ws2812_frame_reader.sv
// Bench: cycle-level reference waveform model for two reader instances (2 LEDs and 1 LED).
module tb_ws2812_frame_reader;

  localparam int P_T0H = 2;
  localparam int P_T1H = 4;
  localparam int P_TBIT = 6;
  localparam int P_TLATCH = 10;
  localparam int D2 = 2 * 24 * P_TBIT + P_TLATCH;
  localparam int D1 = 1 * 24 * P_TBIT + P_TLATCH;

  logic clk = 1'b0;
  logic reset, start0, start1;
  logic busy0, done0, ce0, ws0, busy1, done1, ce1, ws1;
  logic [11:0] addr0, addr1;
  logic [15:0] dout0 = 16'h0;
  logic [15:0] dout1 = 16'h0;
  logic [15:0] mem0 [0:3];
  logic [15:0] mem1 [0:3];

  int checks = 0;
  int failures = 0;
  int base = 0;
  bit track = 1'b0;
  bit sel = 1'b0;
  logic [47:0] rx;
  int ce_cnt;
  int done_c;

  logic ws_o, busy_o, done_o, ce_o;
  logic [11:0] addr_o;
  assign ws_o   = sel ? ws1 : ws0;
  assign busy_o = sel ? busy1 : busy0;
  assign done_o = sel ? done1 : done0;
  assign ce_o   = sel ? ce1 : ce0;
  assign addr_o = sel ? addr1 : addr0;

  always #5 clk = ~clk;

  ws2812_frame_reader #(.NUM_LEDS(2), .T0H(P_T0H), .T1H(P_T1H), .T_BIT(P_TBIT), .T_LATCH(P_TLATCH)) dut (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .mem_addr(addr0), .mem_ce(ce0), .mem_dout(dout0), .ws_dout(ws0));

  ws2812_frame_reader #(.NUM_LEDS(1), .T0H(P_T0H), .T1H(P_T1H), .T_BIT(P_TBIT), .T_LATCH(P_TLATCH)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .mem_addr(addr1), .mem_ce(ce1), .mem_dout(dout1), .ws_dout(ws1));

  // One-cycle-latency frame buffers
  always @(posedge clk) begin
    if (ce0) dout0 <= mem0[addr0[1:0]];
    if (ce1) dout1 <= mem1[addr1[1:0]];
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] grb_model(input logic [15:0] w);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(w) / 2048;
    g6 = (int'(w) / 32) % 64;
    b5 = int'(w) % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 24'(g8 * 65536 + r8 * 256 + b8);
  endfunction

  // Per-cycle comparison against the waveform the frame must produce
  always @(negedge clk) begin
    int c, n, s, d, led, bitn, ph, th;
    logic [23:0] px;
    logic [15:0] w;
    logic e_ws, e_ce;
    #1;
    if (track) begin
      c = (int'($time) - 1 - base - 30) / 10;
      n = sel ? 1 : 2;
      s = n * 24 * P_TBIT;
      d = s + P_TLATCH;
      e_ws = 1'b0;
      e_ce = (c == -2);
      led = 0;
      if (c >= 0 && c < s) begin
        led  = c / (24 * P_TBIT);
        bitn = 23 - (c / P_TBIT) % 24;
        ph   = c % P_TBIT;
        w    = sel ? mem1[led] : mem0[led];
        px   = grb_model(w);
        th   = px[bitn] ? P_T1H : P_T0H;
        e_ws = (ph < th);
        e_ce = ((c % (24 * P_TBIT)) == 0) && (led < n - 1);
        if (ph == P_T0H) rx = {rx[46:0], ws_o};
      end
      check("ws_dout", {47'd0, ws_o}, {47'd0, e_ws});
      check("busy", {47'd0, busy_o}, {47'd0, (c >= -2 && c <= d)});
      check("done", {47'd0, done_o}, {47'd0, (c == d)});
      check("mem_ce", {47'd0, ce_o}, {47'd0, e_ce});
      if (e_ce) check("mem_addr", {36'd0, addr_o}, (c == -2) ? 48'd0 : 48'(led + 1));
      if (ce_o === 1'b1) ce_cnt++;
      if (done_o === 1'b1 && done_c < 0) done_c = c;
    end
  end

  task automatic goto_c(input int x);
    int cur;
    cur = (int'($time) - base - 30) / 10;
    repeat (x - cur) @(negedge clk);
  endtask

  task automatic start_frame(input bit s);
    sel = s;
    base = int'($time);
    rx = 48'd0;
    ce_cnt = 0;
    done_c = -1;
    track = 1'b1;
    if (s) start1 = 1'b1;
    else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", {47'd0, busy0}, 48'd0);
    check("rst_done", {47'd0, done0}, 48'd0);
    check("rst_ce", {47'd0, ce0}, 48'd0);
    check("rst_addr", {36'd0, addr0}, 48'd0);
    check("rst_ws", {47'd0, ws0}, 48'd0);
    check("rst_ws1", {47'd0, ws1}, 48'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame A: pure red then pure green, with a start mid-frame that must be ignored
    mem0[0] = 16'hF800;
    mem0[1] = 16'h07E0;
    start_frame(1'b0);
    goto_c(100);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    goto_c(D2);
    mem0[0] = 16'h0821;
    mem0[1] = 16'hFFFF;
    start0 = 1'b1;
    @(negedge clk);
    check("frameA_stream", rx, 48'h00FF00_FF0000);
    check("frameA_ce_count", 48'(ce_cnt), 48'd2);
    check("frameA_done_offset", 48'(done_c), 48'd298);

    // Frame B: started the cycle after done, then reset during LED 1 bit 10
    start_frame(1'b0);
    goto_c(224);
    track = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ws", {47'd0, ws0}, 48'd0);
    check("midrst_busy", {47'd0, busy0}, 48'd0);
    check("midrst_ce", {47'd0, ce0}, 48'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame C: channel expansion words, re-read from address 0
    start_frame(1'b0);
    goto_c(D2 + 1);
    check("frameC_stream", rx, 48'h040808_FFFFFF);
    check("frameC_ce_count", 48'(ce_cnt), 48'd2);
    check("frameC_done_offset", 48'(done_c), 48'd298);
    track = 1'b0;

    // Frame D: single-LED instance, latch directly after the only LED
    mem1[0] = 16'h07E0;
    repeat (2) @(negedge clk);
    start_frame(1'b1);
    goto_c(D1 + 1);
    check("frameD_stream", rx, 48'h000000_FF0000);
    check("frameD_ce_count", 48'(ce_cnt), 48'd1);
    check("frameD_done_offset", 48'(done_c), 48'd154);
    repeat (5) @(negedge clk);
    track = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
